// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: controller states, default widths
// and the function codes understood by the external shared ALU.
package alu_ctrl_pkg;

    localparam int WIDTH_DEF = 6;
    localparam int FXN_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [FXN_W_DEF-1:0] FXN_ADD = 3'd0;
    localparam logic [FXN_W_DEF-1:0] FXN_SUB = 3'd1;
    localparam logic [FXN_W_DEF-1:0] FXN_AND = 3'd2;
    localparam logic [FXN_W_DEF-1:0] FXN_OR  = 3'd3;
    localparam logic [FXN_W_DEF-1:0] FXN_XOR = 3'd4;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU link and the response
// channel. slave is the arbiter's view, master is the environment's view.
interface alu_arbiter_if #(
    parameter int WIDTH = 6,
    parameter int FXN_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [FXN_W-1:0] req0_fxn;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [FXN_W-1:0] req1_fxn;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [FXN_W-1:0] alu_fxn;
    logic [WIDTH-1:0] alu_x;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_x;
    logic             rsp_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fxn,
        input  req1_valid, req1_a, req1_b, req1_fxn,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_fxn,
        input  alu_x,
        output rsp_valid, rsp_x, rsp_id,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fxn,
        output req1_valid, req1_a, req1_b, req1_fxn,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_fxn,
        output alu_x,
        input  rsp_valid, rsp_x, rsp_id,
        output rsp_ready
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone request always wins, and on contention
// the requester not granted last wins. Priority moves only when a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic prio_reg;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_reg ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_reg <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            prio_reg <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU: grant in IDLE,
// one EXEC cycle to capture the result, then hold the response until accepted.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FXN_W = FXN_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    state_t state_reg;
    state_t state_next;

    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] grant;
    logic       in_idle;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [FXN_W-1:0] fxn_reg;
    logic             id_reg;
    logic [WIDTH-1:0] x_reg;
    logic             rsp_id_reg;

    assign req     = {bus.req1_valid, bus.req0_valid};
    assign in_idle = (state_reg == IDLE);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (in_idle),
        .gnt    (gnt)
    );

    // Ready is gated by rst_n so nothing is accepted while reset is held.
    assign grant = gnt & {2{in_idle & rst_n}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bus.req0_ready = grant[0];
        bus.req1_ready = grant[1];
        bus.rsp_valid  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (grant != 2'b00) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            fxn_reg    <= '0;
            id_reg     <= 1'b0;
            x_reg      <= '0;
            rsp_id_reg <= 1'b0;
        end else begin
            if (grant[1]) begin
                a_reg   <= bus.req1_a;
                b_reg   <= bus.req1_b;
                fxn_reg <= bus.req1_fxn;
                id_reg  <= 1'b1;
            end else if (grant[0]) begin
                a_reg   <= bus.req0_a;
                b_reg   <= bus.req0_b;
                fxn_reg <= bus.req0_fxn;
                id_reg  <= 1'b0;
            end
            if (state_reg == EXEC) begin
                x_reg      <= bus.alu_x;
                rsp_id_reg <= id_reg;
            end
        end
    end

    // The ALU sees only the operand registers, so its inputs are quiet outside EXEC.
    assign bus.alu_a   = a_reg;
    assign bus.alu_b   = b_reg;
    assign bus.alu_fxn = fxn_reg;
    assign bus.rsp_x   = x_reg;
    assign bus.rsp_id  = rsp_id_reg;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the operand and result width.
REQ-002 The block SHALL have parameter FXN_W, default 3, giving the function-select width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-006 The block SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle.
REQ-007 The block SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 The block SHALL have ports req0_fxn / req1_fxn  input  FXN_W  ALU function select.
REQ-009 The block SHALL have ports alu_a, alu_b  output  WIDTH, and alu_fxn  output  FXN_W; these drive the shared combinational ALU.
REQ-010 The block SHALL have port alu_x  input  WIDTH  combinational ALU result.
REQ-011 The block SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_x  output  WIDTH, rsp_id  output  1 (winning requester).

Function
REQ-012 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-013 In IDLE with any reqN_valid high, the block SHALL assert exactly one reqN_ready, combinationally, latch that requester's a/b/fxn and id, and go to EXEC.
REQ-014 When both requesters are valid, the winner SHALL be the one not granted last; after reset requester 0 has priority.
REQ-015 A requester valid alone SHALL win regardless of priority, and the priority pointer SHALL update only on a grant.
REQ-016 reqN_ready SHALL be low in EXEC and RESP, and low in IDLE for any requester that is not valid.
REQ-017 alu_a/alu_b/alu_fxn SHALL come from the operand registers only and SHALL hold their values outside EXEC.
REQ-018 In EXEC the block SHALL capture alu_x into the result register and go to RESP after exactly one cycle.
REQ-019 In RESP rsp_valid SHALL be high and rsp_x/rsp_id SHALL stay stable until a cycle with rsp_ready high; the block then goes to IDLE.
REQ-020 Latency SHALL be as follows: for a grant in cycle T, rsp_valid rises in cycle T+2. Minimum throughput is one operation per 3 cycles.
REQ-021 rsp_valid SHALL NOT depend combinationally on rsp_ready.
REQ-022 A requester that drops valid without a grant SHALL NOT be served.

Reset
REQ-023 Asserting rst_n low at any time, including mid-EXEC or mid-RESP, SHALL immediately force: state IDLE, rsp_valid 0, rsp_x 0, rsp_id 0, operand/fxn registers 0, priority to requester 0; any in-flight operation is discarded.
REQ-024 reqN_ready SHALL be 0 while rst_n is low.

Structure
REQ-025 The shared package alu_ctrl_pkg SHALL hold the state enumeration (IDLE, EXEC, RESP), the WIDTH/FXN_W defaults and the ALU function-code constants.
REQ-026 Two-way round-robin grant logic SHALL be a sub-module named rr_arb2, with inputs req[1:0], an update strobe and clk/rst_n, and output gnt[1:0], one-hot or zero.
REQ-027 The ALU itself SHALL stay outside this block; the bench connects the existing 6-bit ALU to alu_a/alu_b/alu_fxn/alu_x.

Verification
REQ-028 Scenario single op: req0 a=5 b=3 fxn=add-code, rsp_ready=1 -> req0_ready in cycle T, rsp_valid at T+2 with rsp_x=8 and rsp_id=0.
REQ-029 Scenario contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 and each rsp_id matches its grant.
REQ-030 Scenario backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid is held, rsp_x is stable, and no reqN_ready is asserted; the block returns to IDLE the cycle after rsp_ready=1.
REQ-031 Scenario wrap: a=6'h3F b=6'h01 add -> rsp_x=6'h00; subtract a=0 b=1 -> rsp_x=6'h3F.
REQ-032 Scenario reset mid-op: assert rst_n low during EXEC -> all outputs go to 0 immediately; after release, a fresh req1 is granted, and with both valid req0 wins.
REQ-033 Scenario lone requester: req1 is the only one valid right after a req1 grant -> req1 is granted again with no idle cycles beyond the protocol.
